// File: rtl/elevator_pkg.sv
// Shared constants for the elevator scheduler: state encoding, direction codes, default sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package elevator_pkg;

   localparam int DEF_NUM_FLOORS  = 8;
   localparam int DEF_MOVE_CYCLES = 2;
   localparam int DEF_DOOR_CYCLES = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MOVE_UP   = 3'd1,
      MOVE_DOWN = 3'd2,
      DOOR_OPEN = 3'd3,
      EMERGENCY = 3'd4
   } state_t;

endpackage

// File: rtl/elevator_req_picker.sv
// Finds pending floors above/below the car and the SCAN next target (nearest in dir, else nearest opposite, else here).
// Latency: purely combinational.
// Backpressure: none; evaluated continuously from the registered pending set.
module elevator_req_picker
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS,
   parameter int FLOOR_W    = 3
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  dir,
   output logic                  any_above,
   output logic                  any_below,
   output logic [FLOOR_W-1:0]    next_target
);

   logic [FLOOR_W-1:0] near_above;
   logic [FLOOR_W-1:0] near_below;

   // Ascending scan: first hit above is the nearest above, last hit below is the nearest below.
   always_comb begin
      any_above  = 1'b0;
      any_below  = 1'b0;
      near_above = current_floor;
      near_below = current_floor;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (FLOOR_W'(i) > current_floor) && !any_above) begin
            any_above  = 1'b1;
            near_above = FLOOR_W'(i);
         end
         if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
            any_below  = 1'b1;
            near_below = FLOOR_W'(i);
         end
      end
   end

   // Keep-direction preference, falling back to the opposite side, then to the current floor.
   always_comb begin
      next_target = current_floor;
      if (dir == DIR_UP) begin
         if (any_above)      next_target = near_above;
         else if (any_below) next_target = near_below;
      end else begin
         if (any_below)      next_target = near_below;
         else if (any_above) next_target = near_above;
      end
   end

endmodule

// File: rtl/elevator_sched.sv
// SCAN request scheduler and motion sequencer for one car; ELEV_DOOR_REOPEN_EN lets a same-floor call restart the dwell.
// Latency: call captured on the next edge; a decision is taken one edge later; one floor costs MOVE_CYCLES cycles.
// Backpressure: none; emergency_stop freezes motion and timers while request capture continues.
module elevator_sched
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
   parameter int FLOOR_W     = 3,
   parameter int MOVE_CYCLES = DEF_MOVE_CYCLES,
   parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  emergency_stop,
   input  logic [NUM_FLOORS-1:0] call_req,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [FLOOR_W-1:0]    destiny_floor,
   output logic                  move_up,
   output logic                  move_down,
   output logic                  door,
   output logic                  busy
);

   localparam int MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
   localparam logic [MOVE_W-1:0]  MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
   localparam logic [DOOR_W-1:0]  DOOR_LOAD = DOOR_W'(DOOR_CYCLES);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

   state_t              state, state_nxt;
   state_t              saved_state, saved_nxt;
   logic                dir, dir_nxt;
   logic [FLOOR_W-1:0]  floor_nxt, step_floor;
   logic [MOVE_W-1:0]   move_cnt, move_cnt_nxt;
   logic [DOOR_W-1:0]   door_cnt, door_cnt_nxt;
   logic [NUM_FLOORS-1:0] clr_mask;
   logic                reopen;
   logic                any_above, any_below;
   logic [FLOOR_W-1:0]  next_target;

   elevator_req_picker #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_picker (
      .pending       (pending),
      .current_floor (current_floor),
      .dir           (dir),
      .any_above     (any_above),
      .any_below     (any_below),
      .next_target   (next_target)
   );

   // State register, including the state to resume after an emergency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         saved_state <= IDLE;
      end else begin
         state       <= state_nxt;
         saved_state <= saved_nxt;
      end
   end

   // Datapath registers: position, direction, timers, request set and target.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir           <= DIR_UP;
         current_floor <= '0;
         move_cnt      <= '0;
         door_cnt      <= '0;
         pending       <= '0;
         destiny_floor <= '0;
      end else begin
         dir           <= dir_nxt;
         current_floor <= floor_nxt;
         move_cnt      <= move_cnt_nxt;
         door_cnt      <= door_cnt_nxt;
         pending       <= (pending | call_req) & ~clr_mask;
         destiny_floor <= next_target;
      end
   end

   // Next-state logic; emergency has priority and freezes every counter.
   always_comb begin
      state_nxt    = state;
      saved_nxt    = saved_state;
      dir_nxt      = dir;
      floor_nxt    = current_floor;
      move_cnt_nxt = move_cnt;
      door_cnt_nxt = door_cnt;
      clr_mask     = '0;
      reopen       = 1'b0;
      step_floor   = current_floor;
      if (emergency_stop) begin
         if (state != EMERGENCY) begin
            state_nxt = EMERGENCY;
            saved_nxt = state;
         end
      end else begin
         case (state)
            IDLE: begin
               if (pending[current_floor]) begin
                  state_nxt               = DOOR_OPEN;
                  door_cnt_nxt            = DOOR_LOAD;
                  clr_mask[current_floor] = 1'b1;
               end else if ((dir == DIR_UP) ? any_above : any_below) begin
                  state_nxt    = (dir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                  move_cnt_nxt = '0;
               end else if (any_above || any_below) begin
                  dir_nxt      = ~dir;
                  state_nxt    = (dir == DIR_UP) ? MOVE_DOWN : MOVE_UP;
                  move_cnt_nxt = '0;
               end
            end
            MOVE_UP, MOVE_DOWN: begin
               if (move_cnt == MOVE_LAST) begin
                  step_floor   = (state == MOVE_UP) ? current_floor + 1'b1 : current_floor - 1'b1;
                  floor_nxt    = step_floor;
                  move_cnt_nxt = '0;
                  // Only requests already latched before this arrival edge stop the car here.
                  if (pending[step_floor]) begin
                     state_nxt            = DOOR_OPEN;
                     door_cnt_nxt         = DOOR_LOAD;
                     clr_mask[step_floor] = 1'b1;
                  end else if ((state == MOVE_UP && step_floor == TOP_FLOOR) ||
                               (state == MOVE_DOWN && step_floor == '0)) begin
                     state_nxt = IDLE;
                  end
               end else begin
                  move_cnt_nxt = move_cnt + 1'b1;
               end
            end
            DOOR_OPEN: begin
               // A call for the floor the car stands at is absorbed, never left pending.
               clr_mask[current_floor] = 1'b1;
`ifdef ELEV_DOOR_REOPEN_EN
               reopen = call_req[current_floor];
`endif
               if (reopen) begin
                  door_cnt_nxt = DOOR_LOAD;
               end else if (door_cnt <= DOOR_W'(1)) begin
                  state_nxt    = IDLE;
                  door_cnt_nxt = '0;
               end else begin
                  door_cnt_nxt = door_cnt - 1'b1;
               end
            end
            EMERGENCY: state_nxt = saved_state;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Outputs decoded from state; the door stays as it was while halted.
   always_comb begin
      move_up   = (state == MOVE_UP);
      move_down = (state == MOVE_DOWN);
      door      = (state == DOOR_OPEN) || (state == EMERGENCY && saved_state == DOOR_OPEN);
      busy      = (state != IDLE);
   end

endmodule
